// File: rtl/span_line_writer_if.sv
// Span request and line-buffer word-write bundle between the sprite/tile
// front end (master) and span_line_writer (slave).
interface span_line_writer_if #(
  parameter int PIXEL_BITS = 8
);
  logic                    span_valid;
  logic                    span_ready;
  logic [9:0]              span_x0;
  logic [9:0]              span_x1;
  logic [PIXEL_BITS-1:0]   span_color;
  logic [7:0]              pixel_addr;
  logic                    write_pixel;
  logic [3:0]              pixel_write_updated;
  logic [4*PIXEL_BITS-1:0] pixel_data;
  logic                    busy;
  logic                    overrun;

  modport master (
    output span_valid, span_x0, span_x1, span_color,
    input  span_ready, pixel_addr, write_pixel, pixel_write_updated,
           pixel_data, busy, overrun
  );

  modport slave (
    input  span_valid, span_x0, span_x1, span_color,
    output span_ready, pixel_addr, write_pixel, pixel_write_updated,
           pixel_data, busy, overrun
  );
endinterface

// File: rtl/span_line_writer.sv
// Rasterizes horizontal pixel spans into 4-pixel line-buffer word writes,
// one word per clock, with per-pixel updated masks and replicated colour.
//
// state | meaning
// IDLE  | waiting for a span; span_ready high unless line_start
// WRITE | emitting one word write per cycle for the latched span
module span_line_writer #(
  parameter int LINE_WORDS = 160,
  parameter int PIXEL_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_start,
  span_line_writer_if.slave bus
);
  localparam int          LINE_PIXELS = 4 * LINE_WORDS;
  localparam logic [9:0]  X_MAX       = 10'(LINE_PIXELS - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state, state_nxt;
  logic [9:0]            x0_r;
  logic [9:0]            x1e_r;
  logic [7:0]            cur_word;
  logic [PIXEL_BITS-1:0] color_r;
  logic                  overrun_r;
  logic                  accept;
  logic                  drop;
  logic                  last_word;
  logic [9:0]            x1_clamp;
  logic [3:0]            mask;

  assign bus.span_ready = (state == IDLE) && !line_start && rst;
  assign accept         = bus.span_valid && bus.span_ready;
  assign drop           = (bus.span_x0 > bus.span_x1) ||
                          ({1'b0, bus.span_x0} >= 11'(LINE_PIXELS));
  assign x1_clamp       = (bus.span_x1 > X_MAX) ? X_MAX : bus.span_x1;
  assign last_word      = (cur_word == x1e_r[9:2]);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !drop) state_nxt = WRITE;
      WRITE:   if (line_start || last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropped spans leave every latched field alone so idle outputs keep holding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      x0_r      <= '0;
      x1e_r     <= '0;
      cur_word  <= '0;
      color_r   <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (accept && !drop) begin
        x0_r     <= bus.span_x0;
        x1e_r    <= x1_clamp;
        color_r  <= bus.span_color;
        cur_word <= bus.span_x0[9:2];
      end else if (state == WRITE && !line_start && !last_word) begin
        cur_word <= cur_word + 8'd1;
      end
      if (state == WRITE && line_start) overrun_r <= 1'b1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_mask
    assign mask[i] = (state == WRITE) &&
                     ({cur_word, 2'(i)} >= x0_r) &&
                     ({cur_word, 2'(i)} <= x1e_r);
  end

  assign bus.write_pixel         = (state == WRITE);
  assign bus.busy                = (state == WRITE);
  assign bus.pixel_addr          = cur_word;
  assign bus.pixel_write_updated = mask;
  assign bus.pixel_data          = {4{color_r}};
  assign bus.overrun             = overrun_r;
endmodule

// File: tb/tb_span_line_writer.sv
// Self-checking bench for span_line_writer: directed scenarios plus random
// spans checked against a pixel-by-pixel reference model.
module tb_span_line_writer;
  localparam int LW = 160;
  localparam int PB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic line_start = 1'b0;

  span_line_writer_if #(.PIXEL_BITS(PB)) ifc ();

  span_line_writer #(.LINE_WORDS(LW), .PIXEL_BITS(PB)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .bus        (ifc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  wr_t  wq[$];
  wr_t  mon_w;
  logic busy_seen = 1'b0;

  always @(negedge clk) begin
    if (ifc.write_pixel === 1'b1) begin
      mon_w.cyc  = cyc;
      mon_w.addr = ifc.pixel_addr;
      mon_w.mask = ifc.pixel_write_updated;
      mon_w.data = ifc.pixel_data;
      wq.push_back(mon_w);
    end
    if (ifc.busy === 1'b1) busy_seen = 1'b1;
  end

  // Reference: walk every covered pixel and collect the words it touches.
  logic [7:0] exp_addr[$];
  logic [3:0] exp_mask[$];

  task automatic model_span(input int x0, input int x1);
    int xe;
    int last;
    exp_addr.delete();
    exp_mask.delete();
    if (x0 > x1 || x0 >= 4 * LW) return;
    xe = (x1 > 4 * LW - 1) ? 4 * LW - 1 : x1;
    for (int x = x0; x <= xe; x++) begin
      if (exp_addr.size() == 0 || exp_addr[exp_addr.size()-1] != 8'(x / 4)) begin
        exp_addr.push_back(8'(x / 4));
        exp_mask.push_back(4'b0000);
      end
      last = exp_mask.size() - 1;
      exp_mask[last] = exp_mask[last] | 4'(1 << (x % 4));
    end
  endtask

  task automatic drive_accept(input int x0, input int x1, input logic [7:0] col,
                              output int acc);
    @(negedge clk);
    ifc.span_valid = 1'b1;
    ifc.span_x0    = 10'(x0);
    ifc.span_x1    = 10'(x1);
    ifc.span_color = col;
    acc = -1;
    for (int k = 0; k < 400; k++) begin
      if (ifc.span_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout x0=%0d x1=%0d: span_ready never seen", x0, x1);
    end
    @(posedge clk);
    #1 ifc.span_valid = 1'b0;
  endtask

  task automatic run_span(input string name, input int x0, input int x1,
                          input logic [7:0] col);
    int acc;
    int n;
    wq.delete();
    model_span(x0, x1);
    n = exp_addr.size();
    drive_accept(x0, x1, col, acc);
    do @(negedge clk); while (cyc < acc + n + 1);
    checks++;
    if (ifc.span_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_after: span_ready=%b required 1", name, ifc.span_ready);
    end
    #1;
    checks++;
    if (wq.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, wq.size(), n);
    end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      checks++;
      if (wq[k].addr !== exp_addr[k] || wq[k].mask !== exp_mask[k] ||
          wq[k].data !== {4{col}} || wq[k].cyc != acc + 1 + k) begin
        errors++;
        $display("FAIL %s write%0d: addr=%0d mask=%b data=%h cyc=%0d required addr=%0d mask=%b data=%h cyc=%0d",
                 name, k, wq[k].addr, wq[k].mask, wq[k].data, wq[k].cyc,
                 exp_addr[k], exp_mask[k], {4{col}}, acc + 1 + k);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.write_pixel, ifc.pixel_addr, ifc.pixel_write_updated, ifc.pixel_data,
         ifc.busy, ifc.overrun, ifc.span_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: wp=%b addr=%h mask=%b data=%h busy=%b ovr=%b rdy=%b required all 0",
               ifc.write_pixel, ifc.pixel_addr, ifc.pixel_write_updated, ifc.pixel_data,
               ifc.busy, ifc.overrun, ifc.span_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.span_ready !== 1'b1 || ifc.write_pixel !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b wp=%b required 1 0", ifc.span_ready, ifc.write_pixel);
    end
  endtask

  task automatic test_basic();
    run_span("basic", 5, 13, 8'hA5);
    checks++;
    if (wq.size() != 3 || wq[0].mask !== 4'b1110 || wq[2].mask !== 4'b0011 ||
        wq[2].addr !== 8'd3) begin
      errors++;
      $display("FAIL basic_plan: size=%0d required 3 writes with masks 1110..0011 ending at addr 3",
               wq.size());
    end
  endtask

  task automatic test_single();
    run_span("single_639", 639, 639, 8'h3C);
    run_span("single_0", 0, 0, 8'hC3);
  endtask

  task automatic test_drop();
    busy_seen = 1'b0;
    run_span("drop_reversed", 20, 10, 8'h11);
    run_span("drop_offline", 640, 700, 8'h22);
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy: busy_seen=%b required 0", busy_seen);
    end
  endtask

  task automatic test_clamp();
    run_span("clamp", 636, 1000, 8'h5A);
  endtask

  task automatic test_abort();
    int acc;
    wq.delete();
    drive_accept(0, 639, 8'h77, acc);
    do @(negedge clk); while (cyc < acc + 3);
    line_start = 1'b1;
    @(posedge clk);
    #1 line_start = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.write_pixel !== 1'b0 || ifc.overrun !== 1'b1 || ifc.span_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: wp=%b ovr=%b rdy=%b required 0 1 1",
               ifc.write_pixel, ifc.overrun, ifc.span_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wq.size() != 3 || wq[wq.size()-1].addr !== 8'd2) begin
      errors++;
      $display("FAIL abort_writes: count=%0d required 3 ending at addr 2", wq.size());
    end
    run_span("after_abort", 8, 11, 8'h99);
    checks++;
    if (ifc.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: ovr=%b required 1", ifc.overrun);
    end
  endtask

  task automatic test_line_start_idle();
    @(negedge clk);
    ifc.span_valid = 1'b1;
    ifc.span_x0    = 10'd0;
    ifc.span_x1    = 10'd3;
    ifc.span_color = 8'h42;
    line_start     = 1'b1;
    wq.delete();
    #1;
    checks++;
    if (ifc.span_ready !== 1'b0) begin
      errors++;
      $display("FAIL ls_idle_ready: rdy=%b required 0", ifc.span_ready);
    end
    @(posedge clk);
    #1 line_start = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.write_pixel !== 1'b0 || ifc.span_ready !== 1'b1) begin
      errors++;
      $display("FAIL ls_no_accept: wp=%b rdy=%b required 0 1", ifc.write_pixel, ifc.span_ready);
    end
    @(posedge clk);
    #1 ifc.span_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.write_pixel !== 1'b1 || ifc.pixel_addr !== 8'd0 ||
        ifc.pixel_write_updated !== 4'b1111) begin
      errors++;
      $display("FAIL ls_held_accept: wp=%b addr=%0d mask=%b required 1 0 1111",
               ifc.write_pixel, ifc.pixel_addr, ifc.pixel_write_updated);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int a;
    wq.delete();
    @(negedge clk);
    ifc.span_valid = 1'b1;
    ifc.span_x0    = 10'd0;
    ifc.span_x1    = 10'd3;
    ifc.span_color = 8'hE1;
    a = -1;
    for (int k = 0; k < 20 && a < 0; k++) begin
      if (ifc.span_ready === 1'b1) a = cyc;
      else @(negedge clk);
    end
    @(posedge clk);
    #1;
    ifc.span_x0 = 10'd4;
    ifc.span_x1 = 10'd7;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.span_ready === 1'b1) break;
    end
    @(posedge clk);
    #1 ifc.span_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 2", wq.size());
    end else begin
      checks++;
      if (wq[0].addr !== 8'd0 || wq[1].addr !== 8'd1 || wq[0].mask !== 4'b1111 ||
          wq[1].mask !== 4'b1111 || wq[0].cyc != a + 1 || wq[1].cyc != a + 3) begin
        errors++;
        $display("FAIL b2b_writes: addr %0d/%0d mask %b/%b cyc %0d/%0d required 0/1 1111/1111 %0d/%0d",
                 wq[0].addr, wq[1].addr, wq[0].mask, wq[1].mask, wq[0].cyc, wq[1].cyc,
                 a + 1, a + 3);
      end
    end
  endtask

  task automatic test_random();
    int x0;
    int x1;
    for (int t = 0; t < 20; t++) begin
      x0 = $urandom_range(0, 700);
      if ($urandom_range(0, 3) == 0) x1 = $urandom_range(0, 1023);
      else x1 = x0 + $urandom_range(0, 40);
      if (x1 > 1023) x1 = 1023;
      run_span($sformatf("rand%0d", t), x0, x1, 8'($urandom));
    end
  endtask

  task automatic test_reset_mid_span();
    int acc;
    drive_accept(0, 639, 8'hBB, acc);
    do @(negedge clk); while (cyc < acc + 4);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc.write_pixel, ifc.pixel_addr, ifc.pixel_write_updated, ifc.pixel_data,
         ifc.busy, ifc.overrun, ifc.span_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_span: wp=%b addr=%h mask=%b data=%h busy=%b ovr=%b rdy=%b required all 0",
               ifc.write_pixel, ifc.pixel_addr, ifc.pixel_write_updated, ifc.pixel_data,
               ifc.busy, ifc.overrun, ifc.span_ready);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifc.write_pixel !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume: wp=%b required 0", ifc.write_pixel);
    end
  endtask

  initial begin
    ifc.span_valid = 1'b0;
    ifc.span_x0    = '0;
    ifc.span_x1    = '0;
    ifc.span_color = '0;
    test_reset();
    test_basic();
    test_single();
    test_drop();
    test_clamp();
    test_abort();
    test_line_start_idle();
    test_back_to_back();
    test_random();
    test_reset_mid_span();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
